// File: rtl/prefix_pkg.sv
// Shared types for the x86 prefix state tracker.
// Prefix kinds from the decoder and tracker FSM states.
package prefix_pkg;

    typedef enum logic [1:0] {
        PFX_SEG   = 2'd0,
        PFX_REP   = 2'd1,
        PFX_REPNE = 2'd2,
        PFX_LOCK  = 2'd3
    } prefix_kind_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFIXED = 2'd1,
        RESTART  = 2'd2
    } tracker_state_t;

endpackage

// File: rtl/seg_select_mux.sv
// Zero-latency priority mux for the segment register read select.
// A SEG prefix decoded this cycle bypasses the latched override.
module seg_select_mux #(
    parameter int             SR_W   = 2,
    parameter logic [SR_W-1:0] SS_SEL = 2'b10
) (
    input  logic            force_segment,
    input  logic [SR_W-1:0] microcode_sr_rd_sel,
    input  logic            seg_now,
    input  logic [SR_W-1:0] prefix_sr_sel,
    input  logic            seg_valid,
    input  logic [SR_W-1:0] seg_sel,
    input  logic            bp_is_base,
    output logic [SR_W-1:0] sr_rd_sel
);

    always_comb begin
        sr_rd_sel = microcode_sr_rd_sel;
        if (force_segment) begin
            sr_rd_sel = microcode_sr_rd_sel;
        end else if (seg_now) begin
            sr_rd_sel = prefix_sr_sel;
        end else if (seg_valid) begin
            sr_rd_sel = seg_sel;
        end else if (bp_is_base) begin
            sr_rd_sel = SS_SEL;
        end
    end

endmodule

// File: rtl/prefix_state_tracker.sv
// Latches x86 instruction prefixes for the sequencer and bus unit,
// retaining them across an interrupted string instruction.
module prefix_state_tracker
    import prefix_pkg::*;
#(
    parameter int              SR_W         = 2,
    parameter logic [SR_W-1:0] SS_SEL       = 2'b10,
    parameter int              MAX_PREFIXES = 4,
    localparam int             CNT_W        = $clog2(MAX_PREFIXES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             next_instruction,
    input  logic             prefix_valid,
    input  prefix_kind_t     prefix_kind,
    input  logic [SR_W-1:0]  prefix_sr_sel,
    input  logic             force_segment,
    input  logic             bp_is_base,
    input  logic [SR_W-1:0]  microcode_sr_rd_sel,
    input  logic             string_restart,
    output logic [SR_W-1:0]  sr_rd_sel,
    output logic             rep_active,
    output logic             rep_z,
    output logic             lock_active,
    output logic [CNT_W-1:0] prefix_count,
    output logic             prefix_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PREFIXES);

    tracker_state_t   state, state_n;
    logic             seg_valid, seg_valid_n;
    logic [SR_W-1:0]  seg_sel, seg_sel_n;
    logic             rep_active_n, rep_z_n, lock_active_n;
    logic [CNT_W-1:0] count_n;
    logic             overflow_n;
    logic             clear;
    logic             take;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            seg_valid       <= 1'b0;
            seg_sel         <= '0;
            rep_active      <= 1'b0;
            rep_z           <= 1'b0;
            lock_active     <= 1'b0;
            prefix_count    <= '0;
            prefix_overflow <= 1'b0;
        end else begin
            state           <= state_n;
            seg_valid       <= seg_valid_n;
            seg_sel         <= seg_sel_n;
            rep_active      <= rep_active_n;
            rep_z           <= rep_z_n;
            lock_active     <= lock_active_n;
            prefix_count    <= count_n;
            prefix_overflow <= overflow_n;
        end
    end

    always_comb begin
        state_n       = state;
        seg_valid_n   = seg_valid;
        seg_sel_n     = seg_sel;
        rep_active_n  = rep_active;
        rep_z_n       = rep_z;
        lock_active_n = lock_active;
        count_n       = prefix_count;
        overflow_n    = prefix_overflow;
        clear         = 1'b0;
        take          = 1'b0;

        case (state)
            IDLE: begin
                clear = next_instruction;
                take  = prefix_valid;
                if (prefix_valid) state_n = PREFIXED;
            end
            PREFIXED: begin
                if (string_restart && rep_active) begin
                    // Retention wins over a same-cycle boundary.
                    state_n = RESTART;
                    take    = prefix_valid;
                end else begin
                    clear = next_instruction;
                    take  = prefix_valid;
                    if (next_instruction && !prefix_valid) state_n = IDLE;
                end
            end
            RESTART: begin
                if (next_instruction) state_n = PREFIXED;
            end
            default: state_n = IDLE;
        endcase

        if (clear) begin
            seg_valid_n   = 1'b0;
            seg_sel_n     = '0;
            rep_active_n  = 1'b0;
            rep_z_n       = 1'b0;
            lock_active_n = 1'b0;
            count_n       = '0;
            overflow_n    = 1'b0;
        end

        if (take) begin
            if (count_n == CNT_MAX) begin
                overflow_n = 1'b1;
            end else begin
                count_n = count_n + 1'b1;
            end
            case (prefix_kind)
                PFX_SEG: begin
                    seg_valid_n = 1'b1;
                    seg_sel_n   = prefix_sr_sel;
                end
                PFX_REP: begin
                    rep_active_n = 1'b1;
                    rep_z_n      = 1'b1;
                end
                PFX_REPNE: begin
                    rep_active_n = 1'b1;
                    rep_z_n      = 1'b0;
                end
                PFX_LOCK: lock_active_n = 1'b1;
                default: ;
            endcase
        end
    end

    seg_select_mux #(
        .SR_W   (SR_W),
        .SS_SEL (SS_SEL)
    ) u_seg_mux (
        .force_segment       (force_segment),
        .microcode_sr_rd_sel (microcode_sr_rd_sel),
        .seg_now             (prefix_valid && prefix_kind == PFX_SEG),
        .prefix_sr_sel       (prefix_sr_sel),
        .seg_valid           (seg_valid),
        .seg_sel             (seg_sel),
        .bp_is_base          (bp_is_base),
        .sr_rd_sel           (sr_rd_sel)
    );

endmodule

// File: tb/tb_prefix_state_tracker.sv
// Directed bench for prefix_state_tracker with hand-computed expectations.
module tb_prefix_state_tracker;
    import prefix_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next_instruction;
    logic         prefix_valid;
    prefix_kind_t prefix_kind;
    logic [1:0]   prefix_sr_sel;
    logic         force_segment;
    logic         bp_is_base;
    logic [1:0]   microcode_sr_rd_sel;
    logic         string_restart;
    logic [1:0]   sr_rd_sel;
    logic         rep_active;
    logic         rep_z;
    logic         lock_active;
    logic [2:0]   prefix_count;
    logic         prefix_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prefix_state_tracker #(
        .SR_W         (2),
        .SS_SEL       (2'b10),
        .MAX_PREFIXES (4)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .next_instruction    (next_instruction),
        .prefix_valid        (prefix_valid),
        .prefix_kind         (prefix_kind),
        .prefix_sr_sel       (prefix_sr_sel),
        .force_segment       (force_segment),
        .bp_is_base          (bp_is_base),
        .microcode_sr_rd_sel (microcode_sr_rd_sel),
        .string_restart      (string_restart),
        .sr_rd_sel           (sr_rd_sel),
        .rep_active          (rep_active),
        .rep_z               (rep_z),
        .lock_active         (lock_active),
        .prefix_count        (prefix_count),
        .prefix_overflow     (prefix_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        next_instruction = 1'b0;
        prefix_valid     = 1'b0;
        prefix_kind      = PFX_SEG;
        prefix_sr_sel    = 2'd0;
        string_restart   = 1'b0;
    endtask

    task automatic pfx(input prefix_kind_t k, input logic [1:0] sel);
        prefix_valid  = 1'b1;
        prefix_kind   = k;
        prefix_sr_sel = sel;
        tick();
        idle_inputs();
        #1;
    endtask

    task automatic boundary();
        next_instruction = 1'b1;
        tick();
        idle_inputs();
        #1;
    endtask

    initial begin
        reset_n             = 1'b0;
        force_segment       = 1'b0;
        bp_is_base          = 1'b1;
        microcode_sr_rd_sel = 2'd3;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
        #1;

        // 1: reset state
        check("rst_sr", 32'(sr_rd_sel), 32'd2);
        check("rst_rep", 32'(rep_active), 32'd0);
        check("rst_repz", 32'(rep_z), 32'd0);
        check("rst_lock", 32'(lock_active), 32'd0);
        check("rst_cnt", 32'(prefix_count), 32'd0);
        check("rst_ovf", 32'(prefix_overflow), 32'd0);

        // 2: later SEG overwrites, same-cycle bypass
        pfx(PFX_SEG, 2'd0);
        check("seg0_sr", 32'(sr_rd_sel), 32'd0);
        prefix_valid  = 1'b1;
        prefix_kind   = PFX_SEG;
        prefix_sr_sel = 2'd3;
        #1;
        check("seg_bypass", 32'(sr_rd_sel), 32'd3);
        tick();
        idle_inputs();
        #1;
        check("seg3_sr", 32'(sr_rd_sel), 32'd3);
        check("seg_cnt", 32'(prefix_count), 32'd2);
        boundary();
        check("seg_clr_sr", 32'(sr_rd_sel), 32'd2);
        check("seg_clr_cnt", 32'(prefix_count), 32'd0);

        // 3: REP, REPNE, LOCK
        pfx(PFX_REP, 2'd0);
        check("rep_z1", 32'(rep_z), 32'd1);
        pfx(PFX_REPNE, 2'd0);
        pfx(PFX_LOCK, 2'd0);
        check("r3_rep", 32'(rep_active), 32'd1);
        check("r3_repz", 32'(rep_z), 32'd0);
        check("r3_lock", 32'(lock_active), 32'd1);
        check("r3_cnt", 32'(prefix_count), 32'd3);
        check("r3_sr", 32'(sr_rd_sel), 32'd2);
        boundary();
        check("r3_clr_lock", 32'(lock_active), 32'd0);
        check("r3_clr_rep", 32'(rep_active), 32'd0);

        // 4: saturation and overflow
        for (int i = 0; i < 4; i++) pfx(PFX_LOCK, 2'd0);
        check("sat_cnt4", 32'(prefix_count), 32'd4);
        check("sat_ovf0", 32'(prefix_overflow), 32'd0);
        pfx(PFX_SEG, 2'd1);
        check("sat_cnt", 32'(prefix_count), 32'd4);
        check("sat_ovf", 32'(prefix_overflow), 32'd1);
        check("sat_latch", 32'(sr_rd_sel), 32'd1);
        boundary();
        check("sat_clr_ovf", 32'(prefix_overflow), 32'd0);
        check("sat_clr_cnt", 32'(prefix_count), 32'd0);

        // 5: retention across interrupted string op
        pfx(PFX_REP, 2'd0);
        pfx(PFX_SEG, 2'd0);
        string_restart = 1'b1;
        tick();
        idle_inputs();
        #1;
        pfx(PFX_LOCK, 2'd0);
        check("rs_ign_lock", 32'(lock_active), 32'd0);
        check("rs_ign_cnt", 32'(prefix_count), 32'd2);
        boundary();
        check("rs_rep", 32'(rep_active), 32'd1);
        check("rs_sr", 32'(sr_rd_sel), 32'd0);
        check("rs_cnt", 32'(prefix_count), 32'd2);
        boundary();
        check("rs_clr_rep", 32'(rep_active), 32'd0);
        check("rs_clr_sr", 32'(sr_rd_sel), 32'd2);
        check("rs_clr_cnt", 32'(prefix_count), 32'd0);

        // string_restart without REP is ignored
        pfx(PFX_SEG, 2'd1);
        string_restart = 1'b1;
        tick();
        idle_inputs();
        #1;
        boundary();
        check("nrs_cnt", 32'(prefix_count), 32'd0);
        check("nrs_sr", 32'(sr_rd_sel), 32'd2);

        // 6: boundary and prefix in the same cycle, then force
        pfx(PFX_LOCK, 2'd0);
        next_instruction = 1'b1;
        prefix_valid     = 1'b1;
        prefix_kind      = PFX_SEG;
        prefix_sr_sel    = 2'd1;
        tick();
        idle_inputs();
        #1;
        check("nb_cnt", 32'(prefix_count), 32'd1);
        check("nb_sr", 32'(sr_rd_sel), 32'd1);
        check("nb_lock", 32'(lock_active), 32'd0);
        force_segment       = 1'b1;
        microcode_sr_rd_sel = 2'd2;
        #1;
        check("force_sr", 32'(sr_rd_sel), 32'd2);
        force_segment       = 1'b0;
        microcode_sr_rd_sel = 2'd3;
        bp_is_base          = 1'b0;
        boundary();
        check("mc_sr", 32'(sr_rd_sel), 32'd3);

        // reset mid-instruction discards everything
        pfx(PFX_REP, 2'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("mrst_rep", 32'(rep_active), 32'd0);
        check("mrst_cnt", 32'(prefix_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
